// File: rtl/vga_pkg.sv
// Shared defaults and scale-select encoding for the VGA pixel-path blocks.
package vga_pkg;

    localparam int DW_DEF = 16;
    localparam int CW_DEF = 10;

    typedef enum logic [1:0] {
        SCALE_X1   = 2'd0,
        SCALE_X2   = 2'd1,
        SCALE_X4   = 2'd2,
        SCALE_RSVD = 2'd3
    } scale_e;

    // Reserved encoding falls back to x1.
    function automatic logic [1:0] scale_shift(input logic [1:0] sel);
        case (scale_e'(sel))
            SCALE_X2: return 2'd1;
            SCALE_X4: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to align side-band signals with ROM read data.
module vga_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // NOTE: every stage is reset so a reset mid-line flushes in-flight de/win bits.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_sprite_blit.sv
// Places a ROM image at a per-frame position with x1/x2/x4 scaling on the VGA pixel path.
// Define SPRITE_COLORKEY_EN to make ROM words equal to KEY transparent.
module vga_sprite_blit
    import vga_pkg::*;
#(
    parameter int IMG_W   = 90,
    parameter int IMG_H   = 50,
    parameter int AW      = 13,
    parameter int DW      = DW_DEF,
    parameter int CW      = CW_DEF,
    parameter int ROM_LAT = 1
`ifdef SPRITE_COLORKEY_EN
    ,
    parameter logic [DW-1:0] KEY = 16'hF81F
`endif
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          de,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic          frame_start,
    input  logic [CW-1:0] pos_x,
    input  logic [CW-1:0] pos_y,
    input  logic [1:0]    scale_sel,
    input  logic [DW-1:0] bg_rgb,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic [DW-1:0] data_rgb,
    output logic          de_out,
    output logic          in_sprite
);

    localparam int XW  = CW + 3;
    localparam int CLW = $clog2(IMG_W);
    localparam logic [CLW-1:0] COL_LAST = CLW'(IMG_W - 1);
    localparam logic [AW-1:0]  ROW_LAST = AW'((IMG_H - 1) * IMG_W);
    localparam logic [AW-1:0]  ROW_STEP = AW'(IMG_W);

    logic           valid_q, valid_d;
    logic [CW-1:0]  px_q, px_d, py_q, py_d;
    logic [1:0]     sh_q, sh_d;
    logic [AW-1:0]  row_base_q, row_base_d;
    logic [CLW-1:0] col_q, col_d;
    logic [1:0]     hsub_q, hsub_d, vsub_q, vsub_d;
    logic           de_prev_q, de_prev_d;
    logic           line_win_q, line_win_d;
    logic [AW-1:0]  rom_addr_q, rom_addr_d;
    logic [DW-1:0]  data_rgb_q, data_rgb_d;
    logic           de_out_q, de_out_d;
    logic           in_sprite_q, in_sprite_d;

    logic [XW-1:0]  wx_end, wy_end;
    logic [1:0]     sub_last;
    logic           win, line_end;
    logic           d_de, d_win, sprite_px;

    // Window bounds are widened so a sprite hanging off the screen edge cannot wrap.
    always_comb begin
        wx_end   = XW'(px_q) + (XW'(IMG_W) << sh_q) - XW'(1);
        wy_end   = XW'(py_q) + (XW'(IMG_H) << sh_q) - XW'(1);
        sub_last = 2'((3'd1 << sh_q) - 3'd1);
        win      = valid_q && de && !frame_start
                && (XW'(x) >= XW'(px_q)) && (XW'(x) <= wx_end)
                && (XW'(y) >= XW'(py_q)) && (XW'(y) <= wy_end);
        line_end = de_prev_q && !de && line_win_q;
    end

    // NOTE: every *_d gets its hold value first so no branch can infer a latch.
    always_comb begin
        valid_d    = valid_q;
        px_d       = px_q;
        py_d       = py_q;
        sh_d       = sh_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        hsub_d     = hsub_q;
        vsub_d     = vsub_q;
        line_win_d = line_win_q;
        rom_addr_d = rom_addr_q;
        de_prev_d  = de;

        if (frame_start) begin
            valid_d    = 1'b1;
            px_d       = pos_x;
            py_d       = pos_y;
            sh_d       = scale_shift(scale_sel);
            row_base_d = '0;
            col_d      = '0;
            hsub_d     = '0;
            vsub_d     = '0;
            line_win_d = 1'b0;
        end else if (line_end) begin
            // Column restarts from 0 every line, so a clipped right edge never skews the stride.
            col_d      = '0;
            hsub_d     = '0;
            line_win_d = 1'b0;
            if (vsub_q == sub_last) begin
                vsub_d = '0;
                if (row_base_q != ROW_LAST) row_base_d = row_base_q + ROW_STEP;
            end else begin
                vsub_d = vsub_q + 2'd1;
            end
        end else if (win) begin
            line_win_d = 1'b1;
            rom_addr_d = row_base_q + AW'(col_q);
            if (hsub_q == sub_last) begin
                hsub_d = '0;
                if (col_q != COL_LAST) col_d = col_q + CLW'(1);
            end else begin
                hsub_d = hsub_q + 2'd1;
            end
        end
    end

    vga_delay_line #(
        .DEPTH(1 + ROM_LAT),
        .WIDTH(2)
    ) u_align (
        .pclk (pclk),
        .rst_n(rst_n),
        .din  ({de, win}),
        .dout ({d_de, d_win})
    );

`ifdef SPRITE_COLORKEY_EN
    assign sprite_px = d_win && (rom_q != KEY);
`else
    assign sprite_px = d_win;
`endif

    always_comb begin
        data_rgb_d  = '0;
        in_sprite_d = 1'b0;
        de_out_d    = d_de;
        if (d_de) begin
            data_rgb_d  = sprite_px ? rom_q : bg_rgb;
            in_sprite_d = sprite_px;
        end
    end

    // NOTE: state flops take non-blocking assignments only; all next-state logic lives above.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
            sh_q        <= '0;
            row_base_q  <= '0;
            col_q       <= '0;
            hsub_q      <= '0;
            vsub_q      <= '0;
            de_prev_q   <= 1'b0;
            line_win_q  <= 1'b0;
            rom_addr_q  <= '0;
            data_rgb_q  <= '0;
            de_out_q    <= 1'b0;
            in_sprite_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            px_q        <= px_d;
            py_q        <= py_d;
            sh_q        <= sh_d;
            row_base_q  <= row_base_d;
            col_q       <= col_d;
            hsub_q      <= hsub_d;
            vsub_q      <= vsub_d;
            de_prev_q   <= de_prev_d;
            line_win_q  <= line_win_d;
            rom_addr_q  <= rom_addr_d;
            data_rgb_q  <= data_rgb_d;
            de_out_q    <= de_out_d;
            in_sprite_q <= in_sprite_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign data_rgb  = data_rgb_q;
    assign de_out    = de_out_q;
    assign in_sprite = in_sprite_q;

endmodule

// File: tb/tb_vga_sprite_blit.sv
// Bench for vga_sprite_blit: ROM_LAT=1 and ROM_LAT=3 instances on shared stimulus, scoreboarded per instance.
module tb_vga_sprite_blit;

    localparam int IMG_W = 90;
    localparam int IMG_H = 50;
    localparam int AW    = 13;
    localparam int DW    = 16;
    localparam int CW    = 10;
`ifdef SPRITE_COLORKEY_EN
    localparam logic [DW-1:0] KEY = 16'hF81F;
`endif

    typedef struct {
        logic          de;
        logic [DW-1:0] rgb;
        logic          ins;
        int            x;
        int            y;
    } exp_t;

    logic          pclk;
    logic          rst_n;
    logic          de;
    logic [CW-1:0] x, y;
    logic          frame_start;
    logic [CW-1:0] pos_x, pos_y;
    logic [1:0]    scale_sel;
    logic [DW-1:0] bg_rgb;

    logic [AW-1:0] addr1, addr3;
    logic [DW-1:0] q1, q3, data1, data3;
    logic          deo1, deo3, ins1, ins3;
    logic [DW-1:0] r3_q [3];

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb1 [$];
    exp_t sb3 [$];

    bit            started = 0;
    bit            m_valid = 0;
    int            m_px = 0, m_py = 0, m_sh = 0;
    logic [AW-1:0] addr_exp = '0;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
`ifdef SPRITE_COLORKEY_EN
        if (a == '0) return KEY;
`endif
        return DW'(a);
    endfunction

    function automatic bit keyed(input logic [DW-1:0] w);
`ifdef SPRITE_COLORKEY_EN
        return w == KEY;
`else
        return (w != w);
`endif
    endfunction

    vga_sprite_blit #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW), .CW(CW), .ROM_LAT(1)) dut1 (
        .pclk(pclk), .rst_n(rst_n), .de(de), .x(x), .y(y), .frame_start(frame_start),
        .pos_x(pos_x), .pos_y(pos_y), .scale_sel(scale_sel), .bg_rgb(bg_rgb),
        .rom_addr(addr1), .rom_q(q1), .data_rgb(data1), .de_out(deo1), .in_sprite(ins1)
    );

    vga_sprite_blit #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW), .CW(CW), .ROM_LAT(3)) dut3 (
        .pclk(pclk), .rst_n(rst_n), .de(de), .x(x), .y(y), .frame_start(frame_start),
        .pos_x(pos_x), .pos_y(pos_y), .scale_sel(scale_sel), .bg_rgb(bg_rgb),
        .rom_addr(addr3), .rom_q(q3), .data_rgb(data3), .de_out(deo3), .in_sprite(ins3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Synchronous ROM models with 1 and 3 cycles of read latency.
    always @(posedge pclk) q1 <= rom_word(addr1);
    always @(posedge pclk) begin
        r3_q[0] <= rom_word(addr3);
        r3_q[1] <= r3_q[0];
        r3_q[2] <= r3_q[1];
    end
    assign q3 = r3_q[2];

    task automatic check(input string tag, input int px, input int py,
                         input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s at x=%0d y=%0d: observed %h expected %h", tag, px, py, obs, exp);
        end
    endtask

    // One pixel clock: compare what the DUTs show now, then drive new inputs and predict their result.
    task automatic step(input logic i_de, input int i_x, input int i_y, input logic i_fs, input logic i_rst);
        exp_t e;
        exp_t z;
        bit   win;
        int   a;
        logic [DW-1:0] w;

        @(negedge pclk);
        if (started) begin
            check("rom_addr_lat1", -1, -1, 32'(addr1), 32'(addr_exp));
            check("rom_addr_lat3", -1, -1, 32'(addr3), 32'(addr_exp));
        end
        if (sb1.size() > 0) begin
            e = sb1.pop_front();
            check("de_out_lat1",    e.x, e.y, 32'(deo1),  32'(e.de));
            check("data_rgb_lat1",  e.x, e.y, 32'(data1), 32'(e.rgb));
            check("in_sprite_lat1", e.x, e.y, 32'(ins1),  32'(e.ins));
        end
        if (sb3.size() > 0) begin
            e = sb3.pop_front();
            check("de_out_lat3",    e.x, e.y, 32'(deo3),  32'(e.de));
            check("data_rgb_lat3",  e.x, e.y, 32'(data3), 32'(e.rgb));
            check("in_sprite_lat3", e.x, e.y, 32'(ins3),  32'(e.ins));
        end

        de          = i_de;
        x           = CW'(i_x);
        y           = CW'(i_y);
        frame_start = i_fs;
        rst_n       = !i_rst;

        if (i_rst) begin
            z = '{de: 1'b0, rgb: '0, ins: 1'b0, x: i_x, y: i_y};
            sb1.delete();
            sb3.delete();
            repeat (3) sb1.push_back(z);
            repeat (5) sb3.push_back(z);
            m_valid  = 0;
            addr_exp = '0;
            started  = 1;
        end else begin
            win = m_valid && i_de && !i_fs
               && i_x >= m_px && i_x <= m_px + (IMG_W << m_sh) - 1
               && i_y >= m_py && i_y <= m_py + (IMG_H << m_sh) - 1;
            e = '{de: i_de, rgb: '0, ins: 1'b0, x: i_x, y: i_y};
            if (i_de) begin
                e.rgb = bg_rgb;
                if (win) begin
                    a = ((i_y - m_py) >> m_sh) * IMG_W + ((i_x - m_px) >> m_sh);
                    addr_exp = AW'(a);
                    w = rom_word(AW'(a));
                    if (!keyed(w)) begin
                        e.rgb = w;
                        e.ins = 1'b1;
                    end
                end
            end
            sb1.push_back(e);
            sb3.push_back(e);
            if (i_fs) begin
                m_valid = 1;
                m_px    = int'(pos_x);
                m_py    = int'(pos_y);
                m_sh    = (scale_sel == 2'd1) ? 1 : (scale_sel == 2'd2) ? 2 : 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic line(input int yy, input int x0, input int x1);
        for (int xx = x0; xx <= x1; xx++) step(1'b1, xx, yy, 1'b0, 1'b0);
        step(1'b0, 0, yy, 1'b0, 1'b0);
        step(1'b0, 0, yy, 1'b0, 1'b0);
    endtask

    // Drain the pipelines, set the frame parameters, then pulse frame_start.
    task automatic new_frame(input int nx, input int ny, input logic [1:0] ss, input logic [DW-1:0] bg);
        idle(6);
        pos_x     = CW'(nx);
        pos_y     = CW'(ny);
        scale_sel = ss;
        bg_rgb    = bg;
        step(1'b0, 0, 0, 1'b1, 1'b0);
        idle(2);
    endtask

    initial begin
        rst_n       = 1'b0;
        de          = 1'b0;
        x           = '0;
        y           = '0;
        frame_start = 1'b0;
        pos_x       = '0;
        pos_y       = '0;
        scale_sel   = 2'd0;
        bg_rgb      = 16'hABCD;

        repeat (3) step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(4);

        // x1 at (50,50): one line above, whole image, one line below; columns 48..141 straddle both edges.
        new_frame(50, 50, 2'd0, 16'hABCD);
        for (int yy = 49; yy <= 100; yy++) line(yy, 48, 141);

        // x2 at (100,20): window spans x 100..279, y 20..119.
        new_frame(100, 20, 2'd1, 16'h7BEF);
        for (int yy = 19; yy <= 120; yy++) line(yy, 98, 281);

        // x1 at (600,400): right part of every line is off a 640-wide screen.
        new_frame(600, 400, 2'd0, 16'hC618);
        for (int yy = 400; yy <= 450; yy++) line(yy, 596, 639);

        // x4 at (20,10); position and scale move mid-frame and must be ignored.
        new_frame(20, 10, 2'd2, 16'h4208);
        pos_x     = CW'(5);
        scale_sel = 2'd0;
        for (int yy = 10; yy <= 17; yy++) line(yy, 18, 381);

        // Reserved scale code at (0,0), then a reset in the middle of a window line.
        new_frame(0, 0, 2'd3, 16'h2104);
        line(0, 0, 95);
        for (int xx = 0; xx <= 9; xx++) step(1'b1, xx, 1, 1'b0, 1'b0);
        step(1'b1, 10, 1, 1'b0, 1'b1);
        for (int xx = 11; xx <= 40; xx++) step(1'b1, xx, 1, 1'b0, 1'b0);
        step(1'b0, 0, 1, 1'b0, 1'b0);
        step(1'b0, 0, 1, 1'b0, 1'b0);
        line(2, 0, 40);

        // A fresh frame_start brings the sprite back.
        new_frame(0, 0, 2'd0, 16'h2104);
        line(0, 0, 95);
        line(1, 0, 95);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
